// File: rtl/gusn_pkg.sv
// Shared types and constants for the frame loader / perceptron pair.
package gusn_pkg;

  typedef enum logic [1:0] {COLLECT, LAUNCH, WAIT, DONE} state_t;

  localparam logic [1:0] CLS_CIRCLE = 2'b10;
  localparam logic [1:0] CLS_CROSS  = 2'b01;
  localparam logic [1:0] CLS_ERR    = 2'b11;

  localparam logic [24:0] CROSS_FRAME  = 25'h1151151;
  localparam logic [24:0] CIRCLE_FRAME = 25'h0454544;

endpackage

// File: rtl/loader_timeout.sv
// Cycle counter bounding the wait for the perceptron; flags the last allowed cycle.
module loader_timeout #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_term_c
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  assign at_term_c = (cnt == CW'(LIMIT - 1));

  // Holds at the terminal value so it never wraps while still enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !at_term_c) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Packs handshaked image rows into a frame, runs one perceptron classification
// per frame with a timeout, and reports the class as a one-cycle result pulse.
module frame_loader
  import gusn_pkg::*;
#(
  parameter int unsigned ROWS    = 5,
  parameter int unsigned COLS    = 5,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLS-1:0]      row_in,
  input  logic                 row_valid,
  input  logic                 row_sof,
  output logic                 row_ready,
  output logic [ROWS*COLS-1:0] pcpt_in,
  output logic                 pcpt_en,
  input  logic                 pcpt_ready,
  input  logic [1:0]           pcpt_out,
  output logic [1:0]           result,
  output logic                 result_valid,
  output logic                 result_err,
  output logic [CNT_W-1:0]     frames_done
);

  localparam int unsigned FRAME_W = ROWS * COLS;
  localparam int unsigned RC_W    = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t             state;
  logic [RC_W-1:0]    row_cnt;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] frame_nxt_c;
  logic [RC_W-1:0]    wr_idx_c;
  logic               row_acc_c;
  logic               last_row_c;
  logic               tmo_term_c;

  // Acceptance is gated by reset so nothing is taken while rst is high
  assign row_ready  = (state == COLLECT) && !rst;
  assign row_acc_c  = row_valid && row_ready;
  assign wr_idx_c   = row_sof ? '0 : row_cnt;
  assign last_row_c = (wr_idx_c == RC_W'(ROWS - 1));

  // Frame with the incoming row merged into its slot; row 0 lands in the MSBs
  always_comb begin
    frame_nxt_c = frame;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (wr_idx_c == RC_W'(i)) begin
        frame_nxt_c[(ROWS-1-i)*COLS +: COLS] = row_in;
      end
    end
  end

  loader_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == LAUNCH),
    .en       (state == WAIT),
    .at_term_c(tmo_term_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= COLLECT;
      row_cnt      <= '0;
      frame        <= '0;
      pcpt_in      <= '0;
      pcpt_en      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      result_err   <= 1'b0;
      frames_done  <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (row_acc_c) begin
            frame <= frame_nxt_c;
            if (last_row_c) begin
              row_cnt <= '0;
              pcpt_in <= frame_nxt_c;
              pcpt_en <= 1'b1;
              state   <= LAUNCH;
            end else begin
              row_cnt <= wr_idx_c + RC_W'(1);
            end
          end
        end
        // Any ready seen here is a leftover from the previous frame
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (pcpt_ready) begin
            result       <= pcpt_out;
            result_err   <= 1'b0;
            result_valid <= 1'b1;
            pcpt_en      <= 1'b0;
            state        <= DONE;
          end else if (tmo_term_c) begin
            result       <= CLS_ERR;
            result_err   <= 1'b1;
            result_valid <= 1'b1;
            pcpt_en      <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          frames_done <= frames_done + CNT_W'(1);
          state       <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model.
module tb_frame_loader;
  import gusn_pkg::*;

  localparam int unsigned ROWS    = 5;
  localparam int unsigned COLS    = 5;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FW      = ROWS * COLS;

  logic clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  logic             rst;
  logic [COLS-1:0]  row_in;
  logic             row_valid;
  logic             row_sof;
  logic             row_ready;
  logic [FW-1:0]    pcpt_in;
  logic             pcpt_en;
  logic             pcpt_ready;
  logic [1:0]       pcpt_out;
  logic [1:0]       result;
  logic             result_valid;
  logic             result_err;
  logic [CNT_W-1:0] frames_done;

  frame_loader #(
    .ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk_tb), .rst(rst), .row_in(row_in), .row_valid(row_valid),
    .row_sof(row_sof), .row_ready(row_ready), .pcpt_in(pcpt_in),
    .pcpt_en(pcpt_en), .pcpt_ready(pcpt_ready), .pcpt_out(pcpt_out),
    .result(result), .result_valid(result_valid), .result_err(result_err),
    .frames_done(frames_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: rows since the last sof form a frame; once full it
  // occupies one launch cycle, a wait bounded by TIMEOUT, and one result cycle.
  logic [COLS-1:0]  m_rows[$];
  bit               m_busy, m_done;
  int               m_age;
  logic [FW-1:0]    m_pin;
  logic [1:0]       m_res;
  logic             m_err;
  logic [CNT_W-1:0] m_frames;

  always @(posedge clk_tb or posedge rst) begin
    if (rst) begin
      m_rows.delete();
      m_busy = 0; m_done = 0; m_age = 0;
      m_pin = '0; m_res = '0; m_err = 1'b0; m_frames = '0;
    end else if (m_done) begin
      m_done = 0;
      m_frames = m_frames + 1'b1;
    end else if (m_busy) begin
      if (m_age == 0) m_age = 1;
      else if (pcpt_ready) begin
        m_res = pcpt_out; m_err = 1'b0; m_busy = 0; m_done = 1;
      end else if (m_age == int'(TIMEOUT)) begin
        m_res = 2'b11; m_err = 1'b1; m_busy = 0; m_done = 1;
      end else m_age++;
    end else if (row_valid) begin
      if (row_sof) m_rows.delete();
      m_rows.push_back(row_in);
      if (m_rows.size() == int'(ROWS)) begin
        m_pin = '0;
        foreach (m_rows[i]) m_pin = (m_pin << COLS) | FW'(m_rows[i]);
        m_rows.delete();
        m_busy = 1; m_age = 0;
      end
    end
  end

  bit chk_on = 0;
  always @(negedge clk_tb) begin
    if (chk_on) begin
      chk("row_ready",    64'(row_ready),    64'(!rst && !m_busy && !m_done));
      chk("pcpt_en",      64'(pcpt_en),      64'(m_busy));
      chk("result_valid", 64'(result_valid), 64'(m_done));
      chk("result",       64'(result),       64'(m_res));
      chk("result_err",   64'(result_err),   64'(m_err));
      chk("frames_done",  64'(frames_done),  64'(m_frames));
      chk("pcpt_in",      64'(pcpt_in),      64'(m_pin));
    end
  end

  // Perceptron stand-in: ready once enable has been high for more than delay cycles
  int         en_cnt = 0;
  int         delay = 3;
  bit         hold = 0, rnd_out = 0, rnd_delay = 0;
  logic [1:0] out_val = CLS_CROSS;

  task automatic cyc();
    @(posedge clk_tb); #2;
    if (pcpt_en) en_cnt++; else en_cnt = 0;
    if (rnd_delay && en_cnt == 1)
      delay = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 12));
    if (en_cnt > delay) pcpt_ready = 1'b1;
    else if (!hold) pcpt_ready = 1'b0;
    if (en_cnt == 1) pcpt_out = ~out_val;
    else pcpt_out = rnd_out ? 2'($urandom) : out_val;
  endtask

  task automatic send_row(input logic [COLS-1:0] r, input logic s, output int refused);
    bit acc, ok;
    ok = 0; refused = 0;
    row_in = r; row_sof = s; row_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      acc = row_ready;
      cyc();
      if (acc) begin ok = 1; break; end
      refused++;
    end
    if (!ok) chk("row_accept_bound", 64'(0), 64'(1));
    row_valid = 1'b0; row_sof = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int first);
    int rf;
    for (int i = first; i < int'(ROWS); i++)
      send_row(f[(int'(ROWS)-1-i)*int'(COLS) +: COLS], 1'(i == 0), rf);
  endtask

  task automatic wait_done(output int en_cycles);
    bit got;
    got = 0; en_cycles = 0;
    for (int k = 0; k < 300; k++) begin
      if (pcpt_en) en_cycles++;
      if (result_valid) begin got = 1; break; end
      cyc();
    end
    if (!got) chk("result_bound", 64'(0), 64'(1));
  endtask

  initial begin
    int en_c, rf;
    rst = 1'b1; row_in = '0; row_valid = 1'b0; row_sof = 1'b0;
    pcpt_ready = 1'b0; pcpt_out = 2'b00;
    cyc(); cyc();
    chk_on = 1;
    cyc();
    chk("rst_pcpt_en", 64'(pcpt_en), 64'(0));
    chk("rst_row_ready", 64'(row_ready), 64'(0));
    chk("rst_pcpt_in", 64'(pcpt_in), 64'(0));
    chk("rst_frames", 64'(frames_done), 64'(0));
    rst = 1'b0;
    cyc();

    // Cross, ready after 3 wait cycles
    delay = 3; out_val = 2'b01;
    send_frame(25'h1151151, 0);
    wait_done(en_c);
    chk("t1_en_cycles", 64'(en_c), 64'(4));
    chk("t1_pcpt_in", 64'(pcpt_in), 64'(25'h1151151));
    chk("t1_result", 64'(result), 64'(2'b01));
    chk("t1_err", 64'(result_err), 64'(0));
    cyc();
    chk("t1_pulse_once", 64'(result_valid), 64'(0));
    chk("t1_frames", 64'(frames_done), 64'(1));

    // Circle back-to-back with a stale ready held high
    hold = 1; pcpt_ready = 1'b1; out_val = 2'b10;
    send_frame(25'h0454544, 0);
    wait_done(en_c);
    chk("t2_en_cycles", 64'(en_c), 64'(2));
    chk("t2_pcpt_in", 64'(pcpt_in), 64'(25'h0454544));
    chk("t2_result", 64'(result), 64'(2'b10));
    cyc();
    chk("t2_frames", 64'(frames_done), 64'(2));
    hold = 0; pcpt_ready = 1'b0;

    // Resync: three stray rows, then a full frame starting with sof
    delay = 2; out_val = 2'b01;
    send_row(5'b11111, 1'b1, rf);
    send_row(5'b10101, 1'b0, rf);
    send_row(5'b01110, 1'b0, rf);
    chk("t3_no_early_launch", 64'(pcpt_en), 64'(0));
    send_frame(25'h1151151, 0);
    wait_done(en_c);
    chk("t3_en_cycles", 64'(en_c), 64'(3));
    chk("t3_pcpt_in", 64'(pcpt_in), 64'(25'h1151151));
    cyc();

    // Timeout with ready never asserted
    delay = 1000;
    send_frame(25'h0454544, 0);
    wait_done(en_c);
    chk("t4_en_cycles", 64'(en_c), 64'(65));
    chk("t4_result", 64'(result), 64'(2'b11));
    chk("t4_err", 64'(result_err), 64'(1));
    cyc();
    chk("t4_back_to_collect", 64'(row_ready), 64'(1));
    chk("t4_frames", 64'(frames_done), 64'(4));

    // Backpressure: next sof row held valid through the busy cycles
    delay = 1; out_val = 2'b01;
    send_frame(25'h1151151, 0);
    send_row(5'b00100, 1'b1, rf);
    chk("t6_refused", 64'(rf), 64'(3));
    out_val = 2'b10;
    send_frame(25'h0454544, 1);
    wait_done(en_c);
    chk("t6_pcpt_in", 64'(pcpt_in), 64'(25'h0454544));
    chk("t6_result", 64'(result), 64'(2'b10));
    cyc();

    // Reset in the middle of a wait
    delay = 1000;
    send_frame(25'h0454544, 0);
    repeat (10) cyc();
    rst = 1'b1;
    #1;
    chk("t5_en_in_rst", 64'(pcpt_en), 64'(0));
    chk("t5_ready_in_rst", 64'(row_ready), 64'(0));
    chk("t5_rv_in_rst", 64'(result_valid), 64'(0));
    cyc(); cyc();
    rst = 1'b0;
    chk("t5_frames", 64'(frames_done), 64'(0));
    delay = 2; out_val = 2'b01;
    send_frame(25'h1151151, 0);
    wait_done(en_c);
    chk("t5_result", 64'(result), 64'(2'b01));
    chk("t5_err", 64'(result_err), 64'(0));
    cyc();
    chk("t5_frames_after", 64'(frames_done), 64'(1));

    // Random traffic
    rnd_delay = 1; rnd_out = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) hold = ($urandom_range(0, 3) == 0);
      row_valid = ($urandom_range(0, 9) < 7);
      row_sof   = ($urandom_range(0, 9) == 0);
      row_in    = COLS'($urandom);
      rst       = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; row_valid = 1'b0;
    cyc();
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream feeder for the perceptron classifier. Accepts a binary image one row per handshake and packs ROWS rows of COLS pixels into one ROWS*COLS-bit frame.
- Launches the frame into the perceptron with its level-sensitive enable, waits for the perceptron's ready, and returns the 2-bit class to the system as a one-cycle result pulse.
- Bounds every classification with a timeout so a stalled perceptron cannot hang the pipeline.

Parameters:
- ROWS, 5, image rows per frame.
- COLS, 5, pixels per row.
- TIMEOUT, 64, max cycles in WAIT before the error result is forced; must be >= 2.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-high.
- row_in  in  COLS  pixel row; bit COLS-1 = leftmost column.
- row_valid  in  1  row_in is valid this cycle.
- row_sof  in  1  qualifies row_valid: this row is row 0 of a new frame.
- row_ready  out  1  loader accepts a row this cycle.
- pcpt_in  out  ROWS*COLS  frame to the perceptron; row 0 in the MSBs.
- pcpt_en  out  1  perceptron enable.
- pcpt_ready  in  1  perceptron result valid.
- pcpt_out  in  2  perceptron class.
- result  out  2  captured class.
- result_valid  out  1  one-cycle pulse: result and result_err are valid.
- result_err  out  1  timeout occurred; result = 2'b11.
- frames_done  out  CNT_W  count of completed frames, successful or errored.

Behaviour:
- Reset (async assert; takes effect on the next clk edge after deassert): state = COLLECT, row counter = 0, frame register = 0, timeout counter = 0.
- Output reset values: pcpt_in = 0, pcpt_en = 0, result = 0, result_valid = 0, result_err = 0, frames_done = 0, row_ready = 0 while rst is high.
- Any partial frame or in-flight classification is discarded by reset.
- Row acceptance: a row is accepted when row_valid && row_ready at a rising edge.
- The accepted row is written to frame slice [(ROWS-1-r)*COLS +: COLS], where r is the row counter.
- State COLLECT:
  - row_ready = 1, pcpt_en = 0.
  - Accept with row_sof = 1: row is stored as row 0 and the counter becomes 1, even mid-frame (resync). The previously stored partial rows are overwritten and never launched.
  - Accept with row_sof = 0: row is stored at r, then r increments.
  - Accepting the row at r = ROWS-1 (with row_sof = 0, or ROWS = 1): counter returns to 0, pcpt_in is loaded from the full frame, and the state moves to LAUNCH.
- State LAUNCH (1 cycle):
  - pcpt_en = 1, row_ready = 0.
  - pcpt_ready is ignored, which masks a stale ready left over from the previous frame. Next state is WAIT, timeout counter = 0.
- State WAIT:
  - pcpt_en = 1, row_ready = 0, pcpt_in held stable.
  - pcpt_ready = 1: result <= pcpt_out, result_err <= 0, go to DONE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 without ready: result <= 2'b11, result_err <= 1, go to DONE.
  - pcpt_ready arriving in the same cycle as the timeout wins; no error is flagged.
- State DONE (1 cycle):
  - result_valid = 1, pcpt_en = 0, row_ready = 0.
  - frames_done increments, wrapping modulo 2^CNT_W.
  - Next state is COLLECT. result and result_err hold until the next DONE.
- Latency: the last row accepted at edge N gives pcpt_en high from edge N+1. Ready sampled at edge M gives result_valid high in cycle M..M+1.
- pcpt_en always drops for at least 1 cycle (DONE) between frames.
- row_valid outside COLLECT is not accepted; upstream must hold the row.
- row_sof without row_valid has no effect.

Decomposition:
- Shared package gusn_pkg holds:
  - state enum {COLLECT, LAUNCH, WAIT, DONE};
  - class constants CLS_CIRCLE, CLS_CROSS, CLS_ERR = 2'b11;
  - reference frames CROSS_FRAME = 25'h1151151 and CIRCLE_FRAME = 25'h0454544.
- One sub-module, loader_timeout: a counter with clear, enable, and a terminal flag.

Test Plan:
1. Cross: rows 10001,01010,00100,01010,10001 (first with sof); perceptron model returns ready after 3 cycles with out = 2'b01 -> pcpt_in = 25'h1151151, pcpt_en high for 4 cycles, result = 01, result_err = 0, result_valid pulses once, frames_done = 1.
2. Circle back-to-back, rows 00100,01010,10001,01010,00100, with pcpt_ready held high from the previous frame -> LAUNCH ignores the stale ready, pcpt_in = 25'h0454544, result taken from the WAIT-cycle pcpt_out, frames_done = 2.
3. Resync: 3 rows, then a sof row plus 4 more rows -> only one launch, containing the last 5 rows; the first 3 rows never appear on pcpt_in.
4. Timeout: pcpt_ready tied 0, TIMEOUT = 64 -> pcpt_en high for 65 cycles (LAUNCH + 64 WAIT), result = 11, result_err = 1, then return to COLLECT.
5. Reset mid-WAIT: rst pulse -> pcpt_en = 0 and row_ready = 0 while rst is high; no result_valid; frames_done = 0; the next full frame classifies normally.
6. Backpressure: row_valid held high during LAUNCH/WAIT/DONE -> no row accepted; the row is accepted on the first COLLECT cycle.
